stream_pkt_gen_chk: RTL

STREAM_PKT_GEN_CHK -- requirements
Module: stream_pkt_gen_chk

---
 rtl/stream_pkt_pkg.sv | 30 +++
 rtl/stream_pkt_chk.sv | 66 ++++++
 rtl/stream_pkt_gen_chk.sv | 104 ++++++++++
 3 files changed

// File: rtl/stream_pkt_pkg.sv
// stream_pkt_pkg: shared TX state type, LFSR constants and per-word beat generation
package stream_pkt_pkg;
  typedef enum logic {IDLE, SEND} tx_state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction
  // word w of beat `beat` in packet `pkt`; bytes at or past len are masked out
  function automatic word_t beat_word(input logic [31:0] start, input logic [31:0] pkt,
                                      input logic [31:0] beat, input logic [31:0] len,
                                      input logic [31:0] kw, input logic [31:0] w);
    word_t r;
    logic [31:0] val, base;
    val  = start + pkt + beat * (kw >> 2) + w;
    base = beat * kw + (w << 2);
    for (int i = 0; i < 4; i++) begin
      r.keep[i]        = base + 32'(i) < len;
      r.data[8*i +: 8] = r.keep[i] ? val[8*i +: 8] : 8'h0;
    end
    return r;
  endfunction
  function automatic logic beat_last(input logic [31:0] beat, input logic [31:0] len, input logic [31:0] kw);
    return len <= beat * kw + kw;
  endfunction
endpackage

// File: rtl/stream_pkt_chk.sv
// stream_pkt_chk: receive-side checker with LFSR backpressure, packet and error counters
module stream_pkt_chk import stream_pkt_pkg::*; #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [31:0]           start_data,
  input  logic [31:0]           len,
  input  logic [USER_WIDTH-1:0] user,
  input  logic                  bp_en,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic [KEEP_WIDTH-1:0] ins_keep,
  input  logic [USER_WIDTH-1:0] ins_user,
  input  logic                  ins_valid,
  input  logic                  ins_last,
  output logic                  ins_ready,
  output logic [31:0]           rx_pkt_cnt,
  output logic [15:0]           rx_err_cnt
);
  logic [15:0] lfsr, pkt, beat;
  logic over, take, exp_last, err;
  logic [DATA_WIDTH-1:0] exp_data, byte_mask;
  logic [KEEP_WIDTH-1:0] exp_keep;
  assign ins_ready = !bp_en || lfsr[1:0] != 2'b00;
  assign take      = ins_valid && ins_ready && !clear;
  assign exp_last  = beat_last(32'(beat), len, 32'(KEEP_WIDTH));
  for (genvar w = 0; w < DATA_WIDTH/32; w++) begin : g_word
    word_t wd;
    assign wd = beat_word(start_data, 32'(pkt), 32'(beat), len, 32'(KEEP_WIDTH), 32'(w));
    assign exp_data[32*w +: 32] = wd.data;
    assign exp_keep[4*w +: 4]   = wd.keep;
  end
  for (genvar b = 0; b < KEEP_WIDTH; b++) begin : g_mask
    assign byte_mask[8*b +: 8] = {8{ins_keep[b]}};
  end
  assign err = ((ins_data ^ exp_data) & byte_mask) != '0 || ins_keep != exp_keep ||
               ins_last != exp_last || ins_user != (exp_last ? user : '0);
  // `over` marks a packet that ran past its expected last beat; its tail is skipped until ins_last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr       <= LFSR_SEED;
      pkt        <= '0;
      beat       <= '0;
      over       <= 1'b0;
      rx_pkt_cnt <= '0;
      rx_err_cnt <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (clear) begin
        pkt        <= '0;
        beat       <= '0;
        over       <= 1'b0;
        rx_pkt_cnt <= '0;
        rx_err_cnt <= '0;
      end else if (take) begin
        rx_err_cnt <= rx_err_cnt + 16'(!over && err && rx_err_cnt != 16'hFFFF);
        rx_pkt_cnt <= rx_pkt_cnt + 32'(ins_last);
        over       <= !ins_last && (over || exp_last);
        pkt        <= pkt + 16'(ins_last);
        beat       <= (ins_last || exp_last || over) ? 16'd0 : beat + 16'd1;
      end
    end
endmodule

// File: rtl/stream_pkt_gen_chk.sv
// stream_pkt_gen_chk: AXI-Stream test packet generator with matching loopback checker
module stream_pkt_gen_chk import stream_pkt_pkg::*; #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [15:0]           cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [31:0]           cfg_start_data,
  input  logic [USER_WIDTH-1:0] cfg_user,
  input  logic                  cfg_bp_en,
  output logic [DATA_WIDTH-1:0] ots_data,
  output logic [KEEP_WIDTH-1:0] ots_keep,
  output logic [USER_WIDTH-1:0] ots_user,
  output logic                  ots_valid,
  output logic                  ots_last,
  input  logic                  ots_ready,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic [KEEP_WIDTH-1:0] ins_keep,
  input  logic [USER_WIDTH-1:0] ins_user,
  input  logic                  ins_valid,
  input  logic                  ins_last,
  output logic                  ins_ready,
  output logic                  tx_busy,
  output logic [31:0]           tx_pkt_cnt,
  output logic [31:0]           rx_pkt_cnt,
  output logic [15:0]           rx_err_cnt
);
  tx_state_t state, state_nx;
  logic [15:0] num, pkt, beat;
  logic [31:0] len, start_data;
  logic [USER_WIDTH-1:0] user;
  logic bp_en, accept, xfer, last_beat;
  assign accept    = cfg_start && state == IDLE;
  assign xfer      = ots_valid && ots_ready;
  assign last_beat = beat_last(32'(beat), len, 32'(KEEP_WIDTH));
  assign tx_busy   = state == SEND;
  assign ots_valid = tx_busy;
  assign ots_last  = tx_busy && last_beat;
  assign ots_user  = ots_last ? user : '0;
  for (genvar w = 0; w < DATA_WIDTH/32; w++) begin : g_word
    word_t wd;
    assign wd = beat_word(start_data, 32'(pkt), 32'(beat), len, 32'(KEEP_WIDTH), 32'(w));
    assign ots_data[32*w +: 32] = tx_busy ? wd.data : 32'h0;
    assign ots_keep[4*w +: 4]   = tx_busy ? wd.keep : 4'h0;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((accept && cfg_num_pkts != 16'd0) ? SEND : IDLE)
                             : ((xfer && last_beat && pkt == num - 16'd1) ? IDLE : SEND);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      num        <= '0;
      pkt        <= '0;
      beat       <= '0;
      len        <= 32'd1;
      start_data <= '0;
      user       <= '0;
      bp_en      <= 1'b0;
      tx_pkt_cnt <= '0;
    end else if (accept) begin
      num        <= cfg_num_pkts;
      pkt        <= '0;
      beat       <= '0;
      len        <= cfg_len == '0 ? 32'd1 : 32'(cfg_len);
      start_data <= cfg_start_data;
      user       <= cfg_user;
      bp_en      <= cfg_bp_en;
      tx_pkt_cnt <= '0;
    end else if (xfer) begin
      beat       <= last_beat ? 16'd0 : beat + 16'd1;
      pkt        <= pkt + 16'(last_beat);
      tx_pkt_cnt <= tx_pkt_cnt + 32'(last_beat);
    end
  stream_pkt_chk #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .start_data (start_data),
    .len        (len),
    .user       (user),
    .bp_en      (bp_en),
    .ins_data   (ins_data),
    .ins_keep   (ins_keep),
    .ins_user   (ins_user),
    .ins_valid  (ins_valid),
    .ins_last   (ins_last),
    .ins_ready  (ins_ready),
    .rx_pkt_cnt (rx_pkt_cnt),
    .rx_err_cnt (rx_err_cnt)
  );
endmodule
